// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
// Carries the FSM state encodings, the full-word byte-enable constant,
// the legal range of the starvation limit and the byte-lane helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_BUSY = 2'd1,
    ARB_DM_BUSY = 2'd2
  } arb_state_e;

  localparam logic [3:0] BE_WORD = 4'hF;

  // Starvation limit range; the counter is 4 bits wide.
  localparam int STARVE_MIN = 1;
  localparam int STARVE_LIM = 15;

  // One-hot byte enable for a byte access at the given lane.
  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF requester, DM requester and memory-side signals.
// slave : the arbiter's view; master : the requesters/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic              dm_byte;
  logic              dm_ll;
  logic              dm_sc;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_sc_fail;

  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_byte, dm_ll, dm_sc, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata, dm_sc_fail,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_byte, dm_ll, dm_sc, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata, dm_sc_fail,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_link_reg.sv
// LL/SC reservation: one linked word address plus a valid flag.
// sc_ok reports whether the currently presented DM address hits the link.
module mem_link_reg #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gnt,
  input  logic              we,
  input  logic              ll,
  input  logic              sc,
  input  logic [ADDR_W-1:0] addr,
  output logic              sc_ok
);
  logic              link_valid;
  logic [ADDR_W-1:2] link_addr;
  logic              hit;

  assign hit   = link_valid && (link_addr == addr[ADDR_W-1:2]);
  assign sc_ok = hit;

  // LL (re)links; every SC and any store to the linked word breaks the link.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (gnt) begin
      if (ll && !we) begin
        link_valid <= 1'b1;
        link_addr  <= addr[ADDR_W-1:2];
      end else if (we && (sc || hit)) begin
        link_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch and data memory.
// DM wins by default; IF is forced through after STARVE_MAX denied IDLE
// cycles (STARVE_MAX must lie in 1..15).
// Optional LL/SC reservation: define MEM_ARB_LLSC_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);
  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  arb_state_e        state, state_next;
  logic [3:0]        starve_cnt;
  logic              force_if;
  logic              if_gnt, dm_gnt;
  logic              sc_reject;

  logic              mem_req, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              if_rvalid, dm_rvalid;
  logic [DATA_W-1:0] if_rdata, dm_rdata;

  assign force_if = bus.if_req && (starve_cnt == STARVE_LIMIT);

`ifdef MEM_ARB_LLSC_EN
  logic is_ll, is_sc, sc_ok, dm_sc_fail;

  assign is_ll     = bus.dm_ll && !bus.dm_we;
  assign is_sc     = bus.dm_sc && bus.dm_we;
  assign sc_reject = is_sc && !sc_ok;

  mem_link_reg #(.ADDR_W(ADDR_W)) u_link (
    .clk   (clk),
    .rst_n (rst_n),
    .gnt   (dm_gnt),
    .we    (bus.dm_we),
    .ll    (is_ll),
    .sc    (is_sc),
    .addr  (bus.dm_addr),
    .sc_ok (sc_ok)
  );

  assign bus.dm_sc_fail = dm_sc_fail;
`else
  logic unused_bits;

  // Without the reservation LL/SC are plain loads/stores.
  assign unused_bits    = ^{bus.dm_ll, bus.dm_sc, bus.if_addr[1:0]};
  assign sc_reject      = 1'b0;
  assign bus.dm_sc_fail = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_next;
  end

  // Next state and grants; grants only in IDLE and never while in reset.
  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (bus.dm_req && !force_if) begin
          dm_gnt     = rst_n;
          state_next = sc_reject ? ARB_IDLE : ARB_DM_BUSY;
        end else if (bus.if_req) begin
          if_gnt     = rst_n;
          state_next = ARB_IF_BUSY;
        end
      end
      ARB_IF_BUSY, ARB_DM_BUSY: begin
        if (bus.mem_ack) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Count IDLE cycles in which IF asked and lost; saturate at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (state == ARB_IDLE && bus.if_req && starve_cnt != STARVE_LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Launch the memory request on grant, retire it and return data on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      dm_rvalid  <= 1'b0;
      dm_rdata   <= '0;
`ifdef MEM_ARB_LLSC_EN
      dm_sc_fail <= 1'b0;
`endif
    end else begin
      if_rvalid  <= 1'b0;
      dm_rvalid  <= 1'b0;
`ifdef MEM_ARB_LLSC_EN
      dm_sc_fail <= 1'b0;
`endif
      if (dm_gnt) begin
        if (sc_reject) begin
          // Failed SC completes locally without touching memory.
          dm_rvalid  <= 1'b1;
`ifdef MEM_ARB_LLSC_EN
          dm_sc_fail <= 1'b1;
`endif
        end else begin
          mem_req  <= 1'b1;
          mem_we   <= bus.dm_we;
          mem_addr <= {bus.dm_addr[ADDR_W-1:2], 2'b00};
          if (bus.dm_byte) begin
            mem_be    <= lane_be(bus.dm_addr[1:0]);
            mem_wdata <= {4{bus.dm_wdata[7:0]}};
          end else begin
            mem_be    <= BE_WORD;
            mem_wdata <= bus.dm_wdata;
          end
        end
      end else if (if_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_be    <= BE_WORD;
        mem_addr  <= {bus.if_addr[ADDR_W-1:2], 2'b00};
        mem_wdata <= '0;
      end else if (state != ARB_IDLE && bus.mem_ack) begin
        mem_req <= 1'b0;
        if (state == ARB_IF_BUSY) begin
          if_rvalid <= 1'b1;
          if_rdata  <= bus.mem_rdata;
        end else begin
          dm_rvalid <= 1'b1;
          dm_rdata  <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.if_rvalid = if_rvalid;
  assign bus.if_rdata  = if_rdata;
  assign bus.dm_rvalid = dm_rvalid;
  assign bus.dm_rdata  = dm_rdata;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_be    = mem_be;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_MAX = 4).
// LL/SC expectations follow MEM_ARB_LLSC_EN when it is defined.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        auto_ack = 1'b0;
  logic        ack_manual = 1'b0;
  logic [31:0] rdata_drv = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  assign bus.mem_ack   = auto_ack ? bus.mem_req : ack_manual;
  assign bus.mem_rdata = rdata_drv;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One DM transaction issued from IDLE; exp_mem says whether memory is touched.
  task automatic dm_op(input string name, input logic we, input logic ll, input logic sc,
                       input logic [31:0] addr, input logic exp_mem, input logic exp_fail);
    bus.dm_req   = 1'b1;
    bus.dm_we    = we;
    bus.dm_byte  = 1'b0;
    bus.dm_ll    = ll;
    bus.dm_sc    = sc;
    bus.dm_addr  = addr;
    bus.dm_wdata = 32'hC0DE_0000 | addr;
    rdata_drv    = 32'h5A00_0000 | addr;
    #1;
    check({name, "_gnt"}, bus.dm_gnt, 1'b1);
    tick();
    bus.dm_req = 1'b0;
    bus.dm_ll  = 1'b0;
    bus.dm_sc  = 1'b0;
    check({name, "_mem_req"}, bus.mem_req, exp_mem);
    if (bus.mem_req) begin
      check({name, "_mem_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
      ack_manual = 1'b1;
      tick();
      ack_manual = 1'b0;
    end
    check({name, "_rvalid"}, bus.dm_rvalid, 1'b1);
    check({name, "_sc_fail"}, bus.dm_sc_fail, exp_fail);
    if (!we) check({name, "_rdata"}, bus.dm_rdata, 32'h5A00_0000 | addr);
    $display("txn %s we=%0b ll=%0b sc=%0b addr=0x%08h mem=%0b sc_fail=%0b",
             name, we, ll, sc, addr, exp_mem, bus.dm_sc_fail);
    tick();
    check({name, "_rvalid_pulse"}, bus.dm_rvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int grants;
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_byte = 0; bus.dm_ll = 0; bus.dm_sc = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0;

    // Reset: every output low, even with a request pending.
    tick();
    bus.if_req = 1'b1;
    #1;
    check("rst_if_gnt", bus.if_gnt, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_if_rvalid", bus.if_rvalid, 1'b0);
    check("rst_dm_rvalid", bus.dm_rvalid, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
    tick();
    rst_n = 1'b1;

    // 1. IF read at 0x100, ack in the first mem_req cycle.
    bus.if_addr = 32'h100;
    #1;
    check("t1_if_gnt", bus.if_gnt, 1'b1);
    check("t1_dm_gnt", bus.dm_gnt, 1'b0);
    tick();
    bus.if_req = 1'b0;
    check("t1_mem_req", bus.mem_req, 1'b1);
    check("t1_mem_addr", bus.mem_addr, 32'h100);
    check("t1_mem_we", bus.mem_we, 1'b0);
    check("t1_mem_be", {28'h0, bus.mem_be}, 32'hF);
    check("t1_if_rvalid_early", bus.if_rvalid, 1'b0);
    ack_manual = 1'b1;
    rdata_drv  = 32'hDEAD_BEEF;
    tick();
    ack_manual = 1'b0;
    check("t1_if_rvalid", bus.if_rvalid, 1'b1);
    check("t1_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    check("t1_mem_req_drop", bus.mem_req, 1'b0);
    check("t1_dm_rvalid", bus.dm_rvalid, 1'b0);
    $display("txn if_read addr=0x00000100 rdata=0x%08h", bus.if_rdata);
    // Stray ack while IDLE must be ignored.
    ack_manual = 1'b1;
    tick();
    ack_manual = 1'b0;
    check("t1_idle_ack_if", bus.if_rvalid, 1'b0);
    check("t1_idle_ack_dm", bus.dm_rvalid, 1'b0);
    check("t1_idle_ack_req", bus.mem_req, 1'b0);

    // 3. SB at 0x203 with 0xAB, ack delayed one cycle to check hold.
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_byte = 1'b1;
    bus.dm_addr = 32'h203; bus.dm_wdata = 32'h1234_56AB;
    #1;
    check("t3_dm_gnt", bus.dm_gnt, 1'b1);
    tick();
    bus.dm_req = 1'b0;
    check("t3_mem_req", bus.mem_req, 1'b1);
    check("t3_mem_we", bus.mem_we, 1'b1);
    check("t3_mem_be", {28'h0, bus.mem_be}, 32'h8);
    check("t3_mem_addr", bus.mem_addr, 32'h200);
    check("t3_mem_wdata", bus.mem_wdata, 32'hABAB_ABAB);
    tick();
    check("t3_hold_req", bus.mem_req, 1'b1);
    check("t3_hold_be", {28'h0, bus.mem_be}, 32'h8);
    check("t3_no_rvalid", bus.dm_rvalid, 1'b0);
    ack_manual = 1'b1;
    tick();
    ack_manual = 1'b0;
    check("t3_rvalid", bus.dm_rvalid, 1'b1);
    check("t3_sc_fail", bus.dm_sc_fail, 1'b0);
    $display("txn sb addr=0x00000203 be=%b wdata=0x%08h", bus.mem_be, bus.mem_wdata);
    bus.dm_byte = 1'b0;
    tick();

    // 2. Both requesters held; expected grant order D D D D I repeating.
    auto_ack = 1'b1;
    rdata_drv = 32'h1111_2222;
    bus.if_addr = 32'h100;
    bus.dm_we = 1'b0; bus.dm_addr = 32'h300;
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    grants = 0;
    for (int cyc = 0; cyc < 60 && grants < 10; cyc++) begin
      #1;
      if (bus.dm_gnt || bus.if_gnt) begin
        check($sformatf("t2_onehot%0d", grants), bus.dm_gnt & bus.if_gnt, 1'b0);
        check($sformatf("t2_if_wins%0d", grants), bus.if_gnt, (grants % 5 == 4) ? 1'b1 : 1'b0);
        $display("txn grant %0d to %s", grants, bus.if_gnt ? "IF" : "DM");
        grants++;
      end
      tick();
    end
    check("t2_grant_count", grants, 10);
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    tick();
    tick();
    auto_ack = 1'b0;
    check("t2_idle_req", bus.mem_req, 1'b0);

    // 4. LL then SC succeeds; a second SC has no link.
    dm_op("t4_ll40",  1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0);
    dm_op("t4_sc40a", 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
    dm_op("t4_sc40b", 1'b1, 1'b0, 1'b1, 32'h40, !LLSC, LLSC);

    // 5. Plain store to the linked word breaks the link.
    dm_op("t5_ll40",  1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0);
    dm_op("t5_sw40",  1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0);
    dm_op("t5_sc40",  1'b1, 1'b0, 1'b1, 32'h40, !LLSC, LLSC);

    // LL-then-LL re-links to the newer word.
    dm_op("t5_ll40b", 1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0);
    dm_op("t5_ll80",  1'b0, 1'b1, 1'b0, 32'h80, 1'b1, 1'b0);
    dm_op("t5_sc40x", 1'b1, 1'b0, 1'b1, 32'h40, !LLSC, LLSC);
    dm_op("t5_ll80b", 1'b0, 1'b1, 1'b0, 32'h80, 1'b1, 1'b0);
    dm_op("t5_sc80",  1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0);

    // 6. Reset in DM_BUSY abandons the transaction.
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h500;
    #1;
    check("t6_dm_gnt", bus.dm_gnt, 1'b1);
    tick();
    bus.dm_req = 1'b0;
    check("t6_mem_req", bus.mem_req, 1'b1);
    rst_n = 1'b0;
    ack_manual = 1'b1;
    #1;
    check("t6_mem_req_drop", bus.mem_req, 1'b0);
    tick();
    check("t6_no_rvalid", bus.dm_rvalid, 1'b0);
    ack_manual = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_no_rvalid_after", bus.dm_rvalid, 1'b0);
    $display("txn reset during dm_busy");
    dm_op("t6_post_rst", 1'b0, 1'b0, 1'b0, 32'h500, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
